// File: rtl/fifo_pkg.sv
// Shared sizing helpers and the status bundle for the bulk-capable FIFO.
package fifo_pkg;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_ADDR_EXP  = 4;

  function automatic int depth_of(input int aexp);
    return 1 << aexp;
  endfunction

  // Count needs one extra bit so that DEPTH itself is representable.
  function automatic int cnt_w(input int aexp);
    return aexp + 1;
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: load beats flush beats increment.
module fifo_ptr #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          flush,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     ptr <= '0;
    else if (load)  ptr <= load_val;
    else if (flush) ptr <= '0;
    else if (inc)   ptr <= ptr + AW'(1);
  end

endmodule

// File: rtl/fifo_ctrl_bulk.sv
// First-word-fall-through FIFO with bulk load, oldest-first snapshot,
// occupancy count, threshold status and sticky error flags.
module fifo_ctrl_bulk
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE      = DEF_DATA_SIZE,
  parameter int ADDR_SPACE_EXP = DEF_ADDR_EXP,
  parameter int AF_THRESH      = depth_of(ADDR_SPACE_EXP) - 2,
  parameter int AE_THRESH      = 2
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      write_to_fifo,
  input  logic [DATA_SIZE-1:0]                      write_data_in,
  input  logic                                      read_from_fifo,
  output logic [DATA_SIZE-1:0]                      read_data_out,
  input  logic                                      flush,
  input  logic                                      load_all,
  input  logic [ADDR_SPACE_EXP:0]                   load_count,
  input  logic [DATA_SIZE*(1<<ADDR_SPACE_EXP)-1:0]  mem_in,
  output logic [DATA_SIZE*(1<<ADDR_SPACE_EXP)-1:0]  mem_out,
  output logic [ADDR_SPACE_EXP:0]                   count,
  output logic                                      empty,
  output logic                                      full,
  output logic                                      almost_empty,
  output logic                                      almost_full,
  output logic                                      overflow,
  output logic                                      underflow,
  input  logic                                      clear_errors
);

  localparam int DEPTH = depth_of(ADDR_SPACE_EXP);
  localparam int CW    = cnt_w(ADDR_SPACE_EXP);
  localparam int AW    = ADDR_SPACE_EXP;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        ld_n;
  logic                 ov_q, un_q;
  logic                 busy, push_ok, pop_ok, ov_evt, un_evt;
  fifo_status_t         st;

  always_comb begin
    st              = '0;
    st.empty        = (count == '0);
    st.full         = (count == CW'(DEPTH));
    st.almost_empty = (count <= CW'(AE_THRESH));
    st.almost_full  = (count >= CW'(AF_THRESH));
    st.overflow     = ov_q;
    st.underflow    = un_q;
  end

  assign {empty, full, almost_empty, almost_full, overflow, underflow} = st;

  // Full with a concurrent pop still accepts the push: the head slot is
  // read out combinationally before the edge reuses it.
  assign busy    = load_all | flush;
  assign push_ok = !busy & write_to_fifo & (!st.full | read_from_fifo);
  assign pop_ok  = !busy & read_from_fifo & !st.empty;
  assign ov_evt  = !busy & write_to_fifo & st.full & !read_from_fifo;
  assign un_evt  = !busy & read_from_fifo & st.empty;
  assign ld_n    = (load_count > CW'(DEPTH)) ? CW'(DEPTH) : load_count;

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk(clk), .reset(reset), .load(load_all), .load_val('0),
    .flush(flush), .inc(pop_ok), .ptr(rd_ptr)
  );

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk(clk), .reset(reset), .load(load_all), .load_val(ld_n[AW-1:0]),
    .flush(flush), .inc(push_ok), .ptr(wr_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      ov_q  <= 1'b0;
      un_q  <= 1'b0;
    end else begin
      if (load_all)   count <= ld_n;
      else if (flush) count <= '0;
      else            count <= count + CW'(push_ok) - CW'(pop_ok);
      ov_q <= ov_evt | (ov_q & !clear_errors);
      un_q <= un_evt | (un_q & !clear_errors);
    end
  end

  // Storage is deliberately left unreset; stale words are harmless.
  always_ff @(posedge clk) begin
    if (load_all) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= mem_in[i*DATA_SIZE +: DATA_SIZE];
    end else if (push_ok) begin
      mem[wr_ptr] <= write_data_in;
    end
  end

  assign read_data_out = mem[rd_ptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_snap
    logic [AW-1:0] idx;
    assign idx = rd_ptr + AW'(i);
    assign mem_out[i*DATA_SIZE +: DATA_SIZE] = mem[idx];
  end

endmodule

// File: tb/tb_fifo_ctrl_bulk.sv
// Self-checking bench for fifo_ctrl_bulk: vector table plus queue scoreboard.
module tb_fifo_ctrl_bulk;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset, wr, rd, fl, la, ce;
  logic [DW-1:0]     din, rdo;
  logic [4:0]        lc, count;
  logic [DW*DEPTH-1:0] mem_in, mem_out;
  logic              empty, full, ae, af, ov, un;

  fifo_ctrl_bulk dut (
    .clk(clk), .reset(reset), .write_to_fifo(wr), .write_data_in(din),
    .read_from_fifo(rd), .read_data_out(rdo), .flush(fl), .load_all(la),
    .load_count(lc), .mem_in(mem_in), .mem_out(mem_out), .count(count),
    .empty(empty), .full(full), .almost_empty(ae), .almost_full(af),
    .overflow(ov), .underflow(un), .clear_errors(ce)
  );

  always #5 clk = ~clk;

  int nvec = 0, nerr = 0;
  logic [7:0] q[$];
  bit m_ov, m_un;

  typedef struct {
    bit w, r;
    logic [7:0] d;
    int cnt;
    bit af, full, ov, un;
  } vec_t;
  vec_t tbl[34];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int n = q.size();
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("almost_empty", ae, n <= 2);
    chk("almost_full", af, n >= 14);
    chk("overflow", ov, m_ov);
    chk("underflow", un, m_un);
    if (n > 0) chk("head", rdo, q[0]);
    for (int i = 0; i < n; i++) chk("mem_out word", mem_out[i*DW +: DW], q[i]);
  endtask

  // One request cycle; inputs change at posedge+1, checks at posedge+1.
  task automatic op(bit w, bit r, logic [7:0] d, bit f = 0, bit c = 0);
    int n = q.size();
    bit e_ov = 0, e_un = 0;
    wr = w; rd = r; din = d; fl = f; ce = c;
    if (r && n > 0 && !f) chk("pop data", rdo, q[0]);
    if (f) q.delete();
    else begin
      if (r && n > 0) void'(q.pop_front());
      if (w && (n < DEPTH || r)) q.push_back(d);
      e_ov = w && n == DEPTH && !r;
      e_un = r && n == 0;
    end
    m_ov = e_ov | (m_ov & !c);
    m_un = e_un | (m_un & !c);
    @(posedge clk); #1;
    wr = 0; rd = 0; fl = 0; ce = 0;
    check_state();
  endtask

  task automatic bulk_load(logic [4:0] cnt);
    int n = (cnt > DEPTH) ? DEPTH : cnt;
    for (int i = 0; i < DEPTH; i++) mem_in[i*DW +: DW] = 8'(i);
    la = 1; lc = cnt; wr = 1; rd = 1; din = 8'hEE;
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    @(posedge clk); #1;
    la = 0; wr = 0; rd = 0;
    check_state();
  endtask

  initial begin
    reset = 0; wr = 0; rd = 0; fl = 0; la = 0; ce = 0; din = 0; lc = 0; mem_in = '0;
    #12;
    check_state();
    reset = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      tbl[i] = '{1, 0, 8'(i + 1), i + 1, (i + 1) >= 14, i == 15, 0, 0};
    tbl[16] = '{1, 0, 8'hFF, 16, 1, 1, 1, 0};
    for (int i = 0; i < 16; i++)
      tbl[17 + i] = '{0, 1, 8'h00, 15 - i, (15 - i) >= 14, 0, 1, 0};
    tbl[33] = '{0, 1, 8'h00, 0, 0, 0, 1, 1};

    foreach (tbl[i]) begin
      op(tbl[i].w, tbl[i].r, tbl[i].d);
      chk("tbl count", count, tbl[i].cnt);
      chk("tbl almost_full", af, tbl[i].af);
      chk("tbl full", full, tbl[i].full);
      chk("tbl overflow", ov, tbl[i].ov);
      chk("tbl underflow", un, tbl[i].un);
    end

    op(0, 0, 0, 0, 1);
    chk("errors cleared", {ov, un}, 2'b00);

    // Full: pop 0x01 while pushing 0xAA; drain to see 0xAA last.
    for (int i = 0; i < 16; i++) op(1, 0, 8'(i + 1));
    op(1, 1, 8'hAA);
    chk("full push+pop count", count, 16);
    for (int i = 0; i < 16; i++) op(0, 1, 0);

    // Empty: push accepted, pop rejected.
    op(1, 1, 8'hAA);
    chk("empty push+pop count", count, 1);
    chk("empty push+pop underflow", un, 1);
    chk("empty push+pop head", rdo, 8'hAA);
    op(0, 1, 0, 0, 1);

    // Bulk load of 5, then push 0x77 and pop 2.
    bulk_load(5);
    chk("load count", count, 5);
    op(1, 0, 8'h77);
    op(0, 1, 0);
    op(0, 1, 0);
    chk("snapshot word0", mem_out[0 +: 8], 8'h02);
    chk("snapshot word3", mem_out[24 +: 8], 8'h77);
    for (int i = 0; i < 4; i++) op(0, 1, 0);

    bulk_load(5'd31);
    chk("load clamp count", count, 16);
    bulk_load(5'd16);
    op(0, 1, 0);
    op(1, 0, 8'h5A);
    chk("load 16 wr wrap", mem_out[15*8 +: 8], 8'h5A);

    // Flush wins over push; clear_errors loses to a same-cycle underflow.
    op(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) op(1, 0, 8'h30 + 8'(i));
    op(1, 0, 8'h99, 1);
    chk("flush count", count, 0);
    chk("flush empty", empty, 1);
    op(0, 1, 0);
    op(0, 1, 0, 0, 1);
    chk("clear vs underflow", un, 1);

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) op(1, 0, 8'h40 + 8'(i));
    #3 reset = 0;
    #1;
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst almost_empty", ae, 1);
    chk("rst almost_full", af, 0);
    chk("rst overflow", ov, 0);
    chk("rst underflow", un, 0);
    q.delete(); m_ov = 0; m_un = 0;
    #2 reset = 1;
    @(posedge clk); #1;
    op(1, 0, 8'h61);
    chk("post-reset head", rdo, 8'h61);

    // Random interleaving across the pointer wrap.
    for (int i = 0; i < 12; i++) op(1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++)
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    while (q.size() > 0) op(0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_bulk.md
# fifo_ctrl_bulk

Parametrised synchronous first-word-fall-through FIFO. It generalises the team's 16x8 FIFO with configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, and a synchronous flush. Bulk load and bulk snapshot are generalised to the full memory width, and the snapshot is ordered oldest-first. It sits between the block-level datapath (bulk load/dump of a cipher state) and word-serial producers and consumers.

## Interface
- DATA_SIZE, 8, bits per word
- ADDR_SPACE_EXP, 4, address bits; DEPTH = 2**ADDR_SPACE_EXP
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- write_to_fifo  in  1  push request
- write_data_in  in  DATA_SIZE  push data
- read_from_fifo  in  1  pop request
- read_data_out  out  DATA_SIZE  head word, combinational from memory[rd_ptr]
- flush  in  1  synchronous clear of the pointers and count
- load_all  in  1  bulk load
- load_count  in  ADDR_SPACE_EXP+1  number of valid words in mem_in, clamped to DEPTH
- mem_in  in  DATA_SIZE*DEPTH  bulk data; word i is bits [i*DATA_SIZE +: DATA_SIZE]
- mem_out  out  DATA_SIZE*DEPTH  snapshot; word i = memory[(rd_ptr+i) mod DEPTH]
- count  out  ADDR_SPACE_EXP+1  occupancy, 0..DEPTH
- empty, full, almost_empty, almost_full  out  1 each  status
- overflow, underflow  out  1 each  sticky error flags
- clear_errors  in  1  clears both sticky flags

## Operation
- Pointers rd_ptr and wr_ptr are ADDR_SPACE_EXP bits and wrap modulo DEPTH. count is a separate register.
- Status is derived combinationally from the count register:
  - empty = (count==0)
  - full = (count==DEPTH)
  - almost_empty and almost_full are compared against the thresholds.
- Per-cycle priority: load_all > flush > push/pop.
- load_all:
  - memory[i] <= word i of mem_in for all i.
  - rd_ptr <= 0, wr_ptr <= min(load_count,DEPTH) mod DEPTH, count <= min(load_count,DEPTH).
  - Concurrent push/pop/flush are ignored and do not set the error flags.
- flush: rd_ptr, wr_ptr and count are cleared to 0. Memory contents are unchanged. Concurrent push/pop are ignored.
- Push only:
  - If !full: write at wr_ptr, wr_ptr+1, count+1.
  - If full: the word is dropped and overflow <= 1.
- Pop only:
  - If !empty: rd_ptr+1, count-1.
  - If empty: no change and underflow <= 1.
- Push and pop together:
  - Not empty (including full): both are accepted, count is unchanged. When full, the head word is read combinationally before the edge overwrites that slot.
  - Empty: the push is accepted, the pop is rejected, and underflow <= 1.
- clear_errors clears overflow/underflow. An error event in the same cycle wins, so the flag ends at 1.
- Memory is not reset. Entries of mem_out beyond count hold stale data.

## Timing
- Reset (reset==0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
- Push to visible data: a push at edge N into an empty FIFO gives read_data_out valid and empty=0 immediately after edge N (1-cycle latency).
- Pop effect: read_data_out changes to the next word after the popping edge.
- All status outputs, count and mem_out update only after the clock edge. They never depend combinationally on the request inputs.
- Reset asserted mid-operation: all state is abandoned immediately. The first accepted operation after deassertion behaves as from the post-reset empty state.
- Wrap-around: after DEPTH pushes and DEPTH pops in any interleaving, pointers return to their starting value with no loss of order.

## Structure
- Package fifo_pkg holds:
  - localparam helpers for DEPTH and count width
  - a typedef fifo_status_t packing {empty, full, almost_empty, almost_full, overflow, underflow}
- Sub-module fifo_ptr: pointer register with increment, flush and load inputs. It is instantiated twice, for rd_ptr and wr_ptr.
- The memory array, count and flag logic stay in fifo_ctrl_bulk.

## Test plan
- Defaults. Reset, push 0x01..0x10 (16 words):
  - full=1 and count=16.
  - almost_full first asserts after the 14th push.
  - A 17th push of 0xFF sets overflow=1 and does not change memory.
- Pop all 16 words: read_data_out = 0x01..0x10 in order, then empty=1. A further pop sets underflow=1 and count stays 0.
- Simultaneous push/pop:
  - When full, pop 0x01 while pushing 0xAA: count stays 16 and 0xAA is eventually read 16th.
  - When empty, the same pair gives count=1, underflow=1 and read_data_out=0xAA.
- load_all with mem_in words 0x00..0x0F and load_count=5: count=5 and pops return 0x00..0x04. Then push 0x77 and pop 2: mem_out word0=0x02 and word3=0x77.
- Push 6 words, assert flush together with a push: count=0 and empty=1. clear_errors together with an underflowing pop leaves underflow=1.
- Push 3 words, pulse reset low mid-cycle (asynchronously): all outputs take their reset values immediately. Across a wrap, 40 random interleaved operations match a scoreboard.
